// File: rtl/clock_freq_monitor.sv
// clock_freq_monitor: counts clk_mon_in rising edges over a gate window timed by clk_10M_ref and checks the count against EXP_COUNT +/- TOL.
// Define CLK_STUCK_DETECT_EN to add the no-edge (static clock) detector and the clk_stuck output.
module clock_freq_monitor #(
   parameter int unsigned GATE_CYCLES  = 1000,
   parameter int unsigned EXP_COUNT    = 250,
   parameter int unsigned TOL          = 2,
   parameter int unsigned CNT_W        = 12
`ifdef CLK_STUCK_DETECT_EN
   ,
   parameter int unsigned STUCK_CYCLES = 16
`endif
) (
   input  logic             clk_10M_ref,
   input  logic             rst_n,
   input  logic             clk_mon_in,
   input  logic             enable,
   input  logic             fault_clr,
   output logic [CNT_W-1:0] count_out,
   output logic             count_valid,
   output logic             freq_ok,
   output logic             freq_fault,
   output logic             clk_stuck
);

   localparam int unsigned GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned LO_BOUND = (TOL > EXP_COUNT) ? 0 : (EXP_COUNT - TOL);
   localparam int unsigned HI_BOUND = EXP_COUNT + TOL;
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [2:0]        sync_q;
   logic [GATE_W-1:0] gate_q;
   logic [CNT_W-1:0]  edge_cnt_q;
   logic [CNT_W-1:0]  edge_sum;
   logic              mon_edge;
   logic              active;
   logic              terminal;
   logic              capture;
   logic              in_range;
   logic              stuck_set;
   logic              stuck_any;
   logic              win_ok;

   // Synchroniser plus one extra stage for rising-edge detection.
   always_ff @(posedge clk_10M_ref) begin
      if (!rst_n) sync_q <= 3'b000;
      else        sync_q <= {sync_q[1:0], clk_mon_in};
   end

   assign mon_edge = sync_q[1] & ~sync_q[2];

   // FSM state register.
   always_ff @(posedge clk_10M_ref) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; dropping enable returns to IDLE from anywhere.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (enable)   state_d = S_WARMUP;
         S_WARMUP: if (terminal) state_d = S_RUN;
         S_RUN:    state_d = S_RUN;
         default:  state_d = S_IDLE;
      endcase
      if (!enable) state_d = S_IDLE;
   end

   assign active   = (state_q != S_IDLE) && enable;
   assign terminal = (state_q != S_IDLE) && (gate_q == GATE_LAST);
   assign capture  = active && terminal && (state_q == S_RUN);

   // The terminal-cycle edge is folded into the closing window's total.
   assign edge_sum = (edge_cnt_q == CNT_MAX) ? CNT_MAX : (edge_cnt_q + CNT_W'(mon_edge));
   assign in_range = (32'(edge_sum) >= LO_BOUND) && (32'(edge_sum) <= HI_BOUND);
   assign win_ok   = in_range && !stuck_any;

   // Gate and edge counters; both restart at 0 on the first cycle of each window.
   always_ff @(posedge clk_10M_ref) begin
      if (!rst_n || !active) begin
         gate_q     <= '0;
         edge_cnt_q <= '0;
      end else if (terminal) begin
         gate_q     <= '0;
         edge_cnt_q <= '0;
      end else begin
         gate_q     <= gate_q + GATE_W'(1);
         edge_cnt_q <= edge_sum;
      end
   end

`ifdef CLK_STUCK_DETECT_EN
   localparam int unsigned STUCK_W = $clog2(STUCK_CYCLES + 1);
   localparam logic [STUCK_W-1:0] STUCK_LIM = STUCK_W'(STUCK_CYCLES);

   logic [STUCK_W-1:0] idle_cnt_q;
   logic               stuck_q;

   assign stuck_set = (idle_cnt_q == STUCK_LIM) && !mon_edge;
   assign stuck_any = stuck_q || stuck_set;
   assign clk_stuck = stuck_q;

   // No-edge timer, saturating at the limit; cleared by any edge and outside WARMUP/RUN.
   always_ff @(posedge clk_10M_ref) begin
      if (!rst_n || !active) begin
         idle_cnt_q <= '0;
         stuck_q    <= 1'b0;
      end else if (mon_edge) begin
         idle_cnt_q <= '0;
         stuck_q    <= 1'b0;
      end else begin
         if (idle_cnt_q != STUCK_LIM) idle_cnt_q <= idle_cnt_q + STUCK_W'(1);
         if (stuck_set)               stuck_q    <= 1'b1;
      end
   end
`else
   assign stuck_set = 1'b0;
   assign stuck_any = 1'b0;
   assign clk_stuck = 1'b0;
`endif

   // Result registers; a failing window's set takes priority over fault_clr.
   always_ff @(posedge clk_10M_ref) begin
      if (!rst_n) begin
         count_out   <= '0;
         count_valid <= 1'b0;
         freq_ok     <= 1'b0;
         freq_fault  <= 1'b0;
      end else begin
         count_valid <= capture;
         if (capture) begin
            count_out <= edge_sum;
            freq_ok   <= win_ok;
         end else if (stuck_set) begin
            freq_ok   <= 1'b0;
         end
         if (capture && !win_ok) freq_fault <= 1'b1;
         else if (fault_clr)     freq_fault <= 1'b0;
      end
   end

endmodule
